// File: rtl/aes_pkg.sv
// Shared AES definitions: state geometry, the round-stage FSM type and the
// forward/inverse S-box tables used by both the encrypt and decrypt datapaths.
package aes_pkg;

  localparam int AES_STATE_W = 128;
  localparam int AES_BYTE_W  = 8;
  localparam int AES_NCOL    = 4;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fsm_state_t;

  // FIPS-197 forward S-box, indexed by the input byte
  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // FIPS-197 inverse S-box, indexed by the input byte
  localparam logic [7:0] INV_SBOX [0:255] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

endpackage

// File: rtl/mod_inv_sbox.sv
// Single-byte inverse S-box lookup; purely combinational.
module mod_inv_sbox
  import aes_pkg::*;
(
  input  logic [AES_BYTE_W-1:0] data_in,
  output logic [AES_BYTE_W-1:0] data_out
);

  assign data_out = INV_SBOX[data_in];

endmodule

// File: rtl/mod_invsubs.sv
// Column-serial InvSubBytes: one 32-bit column per cycle through four
// inverse S-box lookups, full 128-bit result published after column 3.
module mod_invsubs
  import aes_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load,
  input  logic [AES_STATE_W-1:0] state_in,
  output logic                   busy,
  output logic                   done,
  output logic [AES_STATE_W-1:0] state_out
);

  localparam int COL_W = AES_BYTE_W * 4;

  fsm_state_t             state, state_nxt;
  logic [1:0]             col, col_nxt;
  logic [AES_STATE_W-1:0] work, work_nxt;
  logic [AES_STATE_W-1:0] out_nxt;
  logic                   done_nxt;
  logic [COL_W-1:0]       col_word, col_res;

  always_comb begin
    col_word = '0;
    for (int c = 0; c < AES_NCOL; c++) begin
      if (col == 2'(c)) col_word = work[AES_STATE_W-1-COL_W*c -: COL_W];
    end
  end

  // One lookup per row of the active column; row 0 is the column's top byte
  for (genvar r = 0; r < 4; r++) begin : g_row
    mod_inv_sbox u_inv_sbox (
      .data_in  (col_word[COL_W-1-AES_BYTE_W*r -: AES_BYTE_W]),
      .data_out (col_res[COL_W-1-AES_BYTE_W*r -: AES_BYTE_W])
    );
  end

  always_comb begin
    state_nxt = state;
    col_nxt   = col;
    work_nxt  = work;
    out_nxt   = state_out;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (load) begin
          work_nxt  = state_in;
          col_nxt   = 2'd0;
          state_nxt = RUN;
        end
      end
      RUN: begin
        for (int c = 0; c < AES_NCOL; c++) begin
          if (col == 2'(c)) work_nxt[AES_STATE_W-1-COL_W*c -: COL_W] = col_res;
        end
        // Last column: publish including the column just transformed
        if (col == 2'd3) begin
          out_nxt   = work_nxt;
          done_nxt  = 1'b1;
          col_nxt   = 2'd0;
          state_nxt = IDLE;
        end else begin
          col_nxt = col + 2'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      col       <= 2'd0;
      work      <= '0;
      state_out <= '0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      col       <= col_nxt;
      work      <= work_nxt;
      state_out <= out_nxt;
      done      <= done_nxt;
    end
  end

  assign busy = (state == RUN);

endmodule

// File: tb/tb_mod_invsubs.sv
// Self-checking bench for mod_invsubs using an independent GF(2^8) S-box
// model and a scoreboard queue of expected results.
module tb_mod_invsubs;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         load;
  logic [127:0] state_in;
  logic         busy;
  logic         done;
  logic [127:0] state_out;

  int checks = 0;
  int passed = 0;
  logic [127:0] exp_q[$];
  logic [127:0] last_out = '0;

  typedef struct {
    logic [127:0] din;
    logic [127:0] expv;
  } vec_t;
  vec_t vecs[5];

  mod_invsubs dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .state_in  (state_in),
    .busy      (busy),
    .done      (done),
    .state_out (state_out)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (maps 0 to 0)
  function automatic logic [7:0] ginv(input logic [7:0] x);
    logic [7:0] r, base;
    logic [7:0] e;
    r = 8'h01; base = x; e = 8'd254;
    for (int i = 0; i < 8; i++) begin
      if (e[0]) r = gmul(r, base);
      base = gmul(base, base);
      e = e >> 1;
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox_model(input logic [7:0] x);
    logic [7:0] b;
    b = ginv(x);
    return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox_model(input logic [7:0] y);
    return ginv(rotl(y, 1) ^ rotl(y, 3) ^ rotl(y, 6) ^ 8'h05);
  endfunction

  function automatic logic [127:0] invsubs_model(input logic [127:0] s);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[127-8*k -: 8] = inv_sbox_model(s[127-8*k -: 8]);
    return r;
  endfunction

  function automatic logic [127:0] subs_model(input logic [127:0] s);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[127-8*k -: 8] = sbox_model(s[127-8*k -: 8]);
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check_output(input string name, input logic [127:0] actual, input logic [127:0] required);
    checks++;
    if (actual === required) passed++;
    else $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, required);
  endtask

  // Scoreboard: pop on every done, otherwise state_out must hold
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (done) begin
        if (exp_q.size() == 0) check_output("unexpected_done", 128'd1, 128'd0);
        else check_output("result", state_out, exp_q.pop_front());
      end else begin
        check_output("hold_out", state_out, last_out);
      end
      last_out = state_out;
    end
  end

  always @(negedge rst_n) last_out = '0;

  task automatic apply_stimulus(input logic [127:0] din, input logic [127:0] expv, input string name);
    int n;
    load = 1'b1;
    state_in = din;
    exp_q.push_back(expv);
    @(posedge clk); #1;
    load = 1'b0;
    state_in = rand128();
    n = 0;
    while (busy && n < 10) begin
      n++;
      // A load during busy must be ignored
      load = (n == 2);
      @(posedge clk); #1;
    end
    load = 1'b0;
    check_output({name, "_busy_cycles"}, 128'(n), 128'd4);
    check_output({name, "_done"}, 128'(done), 128'd1);
    @(posedge clk); #1;
    check_output({name, "_done_width"}, 128'(done), 128'd0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cnt;
    int n;
    int done_at[$];
    logic [127:0] p;

    vecs[0] = '{{16{8'h63}}, 128'h0};
    vecs[1] = '{{4{32'h00_52_16_ED}}, {4{32'h52_48_FF_53}}};
    vecs[2] = '{{16{8'h00}}, {16{8'h52}}};
    vecs[3] = '{{16{8'hFF}}, {16{8'h7D}}};
    vecs[4] = '{128'h00112233_44556677_8899AABB_CCDDEEFF,
                invsubs_model(128'h00112233_44556677_8899AABB_CCDDEEFF)};

    rst_n = 1'b0;
    load = 1'b0;
    state_in = '0;
    #12;
    check_output("reset_busy", 128'(busy), 128'd0);
    check_output("reset_done", 128'(done), 128'd0);
    check_output("reset_out", state_out, 128'd0);
    rst_n = 1'b1;

    // First edge after reset release must accept the load
    for (int i = 0; i < 5; i++) apply_stimulus(vecs[i].din, vecs[i].expv, $sformatf("vec%0d", i));

    // Continuous load: accepts on cycles 0, 5, 10
    for (int i = 0; i < 12; i++) begin
      state_in = rand128();
      load = 1'b1;
      if (i % 5 == 0) exp_q.push_back(invsubs_model(state_in));
      @(posedge clk); #1;
      if (done) done_at.push_back(i);
    end
    load = 1'b0;
    check_output("cont_completions", 128'(done_at.size()), 128'd2);
    check_output("cont_first_at", 128'((done_at.size() > 0) ? done_at[0] : -1), 128'd4);
    check_output("cont_second_at", 128'((done_at.size() > 1) ? done_at[1] : -1), 128'd9);
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      n++;
      @(posedge clk); #1;
    end
    check_output("cont_drain", 128'(exp_q.size()), 128'd0);
    @(posedge clk); #1;

    // Reset during column 2 aborts with no completion
    load = 1'b1;
    state_in = rand128();
    exp_q.push_back(invsubs_model(state_in));
    @(posedge clk); #1;
    load = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_output("mid_busy_before", 128'(busy), 128'd1);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check_output("mid_rst_busy", 128'(busy), 128'd0);
    check_output("mid_rst_done", 128'(done), 128'd0);
    check_output("mid_rst_out", state_out, 128'd0);
    #1;
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (done) cnt++;
    end
    check_output("mid_no_done", 128'(cnt), 128'd0);
    apply_stimulus(vecs[1].din, vecs[1].expv, "after_reset");

    // Round trip through the forward model
    for (int k = 0; k < 200; k++) begin
      p = rand128();
      apply_stimulus(subs_model(p), p, "roundtrip");
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
